digit_scanner: RTL
==================

DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter DIGITS, default 4, meaning: number of multiplexed 7-segment digits, legal range 2..8.
REQ-002 Parameter PRESCALE_BITS, default 12, meaning: each digit slot lasts 2^PRESCALE_BITS clocks, legal range 3..20.
REQ-003 Parameter GUARD, default 2, meaning: anti-ghosting clocks at the start of each slot with all digit enables off; must be less than 2^PRESCALE_BITS.
REQ-004 Port i_clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 Port i_reset, input, 1, synchronous active-high reset.
REQ-006 Port i_load, input, 1, single-cycle strobe that captures i_value, i_dp and i_lzs into the shadow register.
REQ-007 Port i_value, input, 4*DIGITS, BCD nibbles; digit 0 (rightmost) is bits [3:0].
REQ-008 Port i_dp, input, DIGITS, decimal-point request per digit.
REQ-009 Port i_lzs, input, 1, leading-zero suppression enable.
REQ-010 Port o_val, output, 4, nibble for the active digit, fed to the BCD-to-7-segment converter val input.
REQ-011 Port o_dec, output, 1, decimal point for the active digit, fed to the converter dec input.
REQ-012 Port o_dig, output, DIGITS, one-hot active-high digit enable; all zero when no digit is lit.
REQ-013 Port o_frame, output, 1, one-clock pulse marking the start of each frame.

Function
REQ-014 The block SHALL keep a slot counter of PRESCALE_BITS bits that increments every clock and wraps to 0.
REQ-015 The block SHALL keep a digit index of 0..DIGITS-1 that advances when the slot counter wraps, and wraps from DIGITS-1 to 0.
REQ-016 The block SHALL copy the shadow register into the display register on the clock where the index wraps to 0 (frame boundary), but only when the pending flag is set; the copy SHALL clear the pending flag.
REQ-017 i_load SHALL write the shadow register and set the pending flag on any cycle.
REQ-018 If i_load coincides with a frame boundary, the display register SHALL take the old shadow contents, the shadow SHALL take the new inputs, and the pending flag SHALL stay set.
REQ-019 o_val, o_dec, o_dig and o_frame SHALL be registered; each SHALL reflect the counter, index and display state of the preceding cycle (one-clock latency).
REQ-020 o_val and o_dec SHALL carry the display-register nibble and dp bit for the current index for the whole slot, guard included.
REQ-021 o_dig SHALL be all zero while the slot counter is below GUARD; otherwise it SHALL be one-hot at bit index, unless the digit is blanked.
REQ-022 A digit i>0 SHALL be blanked (o_dig all zero, o_val and o_dec still driven) when lzs is set in the display register, the nibbles at i and all higher digits are zero, and dp is clear at i and all higher digits.
REQ-023 Digit 0 SHALL never be blanked.
REQ-024 Nibbles 10..15 SHALL be passed through unchanged and SHALL count as non-zero for suppression.
REQ-025 o_frame SHALL pulse high for exactly one clock, one cycle after each index wrap to 0.

Reset
REQ-026 While i_reset is high, the slot counter, index, shadow, display register, pending flag, o_val, o_dec, o_dig and o_frame SHALL all be 0; i_load SHALL be ignored.
REQ-027 Reset asserted mid-slot or mid-frame SHALL abort immediately; the first clock after deassertion SHALL be slot count 0 of digit 0.
REQ-028 The block SHALL assert no output until the first post-reset rising edge.

Verification (DIGITS=4, PRESCALE_BITS=4, GUARD=2)
REQ-029 Reset, then load 0x1234 with dp=0000 and lzs=0 -> the first frame after the load shows 4,3,2,1 on digits 0..3; o_dig=0001 during counts 2..15 of slot 0; o_frame pulses every 64 clocks.
REQ-030 Load 0x0050 with lzs=1 and dp=0000 -> digits 2 and 3 blanked, digit 1 shows 5, digit 0 shows 0; with dp=0100 only digit 3 is blanked.
REQ-031 Load 0x9999, then load 0x0001 at exactly the frame-boundary clock -> the following frame shows 9999 and the frame after shows 0001.
REQ-032 Two loads within one frame (0x1111, then 0x2222) -> the next frame shows 2222 only, and 1111 is never displayed.
REQ-033 Assert i_reset for 1 clock during slot 2, count 7 -> the outputs go to zero, and slot 0 count 0 follows; 0x0000 is shown until the next load.
REQ-034 Load 0xABCD -> o_val carries 13,12,11,10 unchanged, and no digit is blanked even with lzs=1.

Source files
------------

// File: rtl/digit_scanner.sv
// Multiplexed 7-segment digit scanner. A slot prescaler steps a digit index, and the display
// value is double-buffered so that it changes only on a frame boundary. The scanner also
// applies a guard interval and leading-zero blanking.
module digit_scanner #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned PRESCALE_BITS = 12,
  parameter int unsigned GUARD         = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic [4*DIGITS-1:0] i_value,
  input  logic [DIGITS-1:0]   i_dp,
  input  logic                i_lzs,
  output logic [3:0]          o_val,
  output logic                o_dec,
  output logic [DIGITS-1:0]   o_dig,
  output logic                o_frame
);

  localparam int unsigned              IDX_W     = $clog2(DIGITS);
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [PRESCALE_BITS-1:0] GUARD_CNT = PRESCALE_BITS'(GUARD);

  logic [PRESCALE_BITS-1:0] slot_cnt;
  logic [IDX_W-1:0]         idx;
  logic [4*DIGITS-1:0]      shadow_val, disp_val;
  logic [DIGITS-1:0]        shadow_dp, disp_dp;
  logic                     shadow_lzs, disp_lzs, pending;
  logic                     slot_wrap, frame_end;
  logic [DIGITS-1:0]        lead_zero, dig_onehot;

  always_comb begin
    logic run;
    slot_wrap  = &slot_cnt;
    frame_end  = slot_wrap && (idx == LAST_IDX);
    dig_onehot = '0;
    dig_onehot[idx] = 1'b1;
    // Walk down from the top digit. A digit can be blanked only while every digit from the
    // top down to it is zero with no decimal point.
    run       = disp_lzs;
    lead_zero = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      run = run && (disp_val[4*(DIGITS-1-k) +: 4] == 4'd0) && !disp_dp[DIGITS-1-k];
      lead_zero[DIGITS-1-k] = run;
    end
    lead_zero[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      slot_cnt   <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      shadow_lzs <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_lzs   <= 1'b0;
      pending    <= 1'b0;
      o_val      <= '0;
      o_dec      <= 1'b0;
      o_dig      <= '0;
      o_frame    <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + PRESCALE_BITS'(1);
      if (slot_wrap)
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      if (frame_end && pending) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
        disp_lzs <= shadow_lzs;
      end
      // A load on the boundary clock refills the shadow as the old contents move to the display.
      // The pending flag therefore stays set for the next frame.
      if (i_load) begin
        shadow_val <= i_value;
        shadow_dp  <= i_dp;
        shadow_lzs <= i_lzs;
        pending    <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
      o_val   <= disp_val[4*idx +: 4];
      o_dec   <= disp_dp[idx];
      o_dig   <= ((slot_cnt < GUARD_CNT) || lead_zero[idx]) ? '0 : dig_onehot;
      o_frame <= (slot_cnt == '0) && (idx == '0);
    end
  end

endmodule
